// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode control stage: fetches 16-bit instructions over a
// req/valid handshake and drives register pointers, ALU op and a write strobe.
module instr_sequencer #(
  parameter int PC_W   = 8,
  parameter int DATA_W = 13
) (
  input  logic            clk,
  input  logic            Reset,
  input  logic            Start,
  output logic            InstrReq,
  output logic [PC_W-1:0] InstrAddr,
  input  logic [15:0]     InstrData,
  input  logic            InstrValid,
  output logic [2:0]      R1,
  output logic [2:0]      R2,
  output logic [2:0]      R3,
  output logic [2:0]      ALU_Op,
  output logic            WriteFlag,
  output logic            Busy,
  output logic            Halted,
  output logic [PC_W-1:0] PC
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_WRITEBACK,
    S_HALTED
  } state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:3]     ir_q, ir_d;
  logic [2:0]      r1_q, r1_d;
  logic [2:0]      r2_q, r2_d;
  logic [2:0]      r3_q, r3_d;
  logic [2:0]      alu_q, alu_d;

  logic [3:0]      opcode;
  logic            op_writes;
  logic            unused_bits;

  // Low instruction bits carry no meaning; DATA_W only documents the datapath.
  assign unused_bits = ^{InstrData[2:0], DATA_W > 0};

  assign opcode    = ir_q[15:12];
  assign op_writes = (opcode >= 4'd1) && (opcode <= 4'd6);

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      r1_q    <= '0;
      r2_q    <= '0;
      r3_q    <= '0;
      alu_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      r1_q    <= r1_d;
      r2_q    <= r2_d;
      r3_q    <= r3_d;
      alu_q   <= alu_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    r1_d    = r1_q;
    r2_d    = r2_q;
    r3_d    = r3_q;
    alu_d   = alu_q;
    unique case (state_q)
      S_IDLE, S_HALTED: begin
        if (Start) begin
          pc_d    = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (InstrValid) begin
          ir_d    = InstrData[15:3];
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        // HALT leaves the pointer/op registers untouched.
        if (opcode == 4'hF) begin
          state_d = S_HALTED;
        end else begin
          r1_d    = ir_q[11:9];
          r2_d    = ir_q[8:6];
          r3_d    = ir_q[5:3];
          alu_d   = op_writes ? opcode[2:0] : 3'd0;
          state_d = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        state_d = S_WRITEBACK;
      end
      S_WRITEBACK: begin
        pc_d    = pc_q + PC_W'(1);
        state_d = S_FETCH;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign InstrReq  = (state_q == S_FETCH);
  assign InstrAddr = pc_q;
  assign PC        = pc_q;
  assign R1        = r1_q;
  assign R2        = r2_q;
  assign R3        = r3_q;
  assign ALU_Op    = alu_q;
  // Gated by Reset so a write due in the reset cycle never reaches the regfile.
  assign WriteFlag = (state_q == S_WRITEBACK) && op_writes && !Reset;
  assign Busy      = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                     (state_q == S_EXECUTE) || (state_q == S_WRITEBACK);
  assign Halted    = (state_q == S_HALTED);

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: cycle table, directed corner sequences, and
// random programs checked against an instruction-level timing model.
module tb_instr_sequencer;
  localparam int PC_W = 8;

  logic            clk = 1'b0;
  logic            Reset = 1'b1;
  logic            Start = 1'b0;
  logic            InstrReq;
  logic [PC_W-1:0] InstrAddr;
  logic [15:0]     InstrData = '0;
  logic            InstrValid = 1'b0;
  logic [2:0]      R1, R2, R3, ALU_Op;
  logic            WriteFlag, Busy, Halted;
  logic [PC_W-1:0] PC;

  always #5 clk = ~clk;

  instr_sequencer #(.PC_W(PC_W), .DATA_W(13)) dut (
    .clk(clk), .Reset(Reset), .Start(Start),
    .InstrReq(InstrReq), .InstrAddr(InstrAddr), .InstrData(InstrData),
    .InstrValid(InstrValid), .R1(R1), .R2(R2), .R3(R3), .ALU_Op(ALU_Op),
    .WriteFlag(WriteFlag), .Busy(Busy), .Halted(Halted), .PC(PC)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [15:0] mem [256];
  int  wait_q[$];
  bit  fetching = 1'b0;
  int  cur_wait = 0;

  int exp_wf[256], exp_req[256], exp_pc[256], exp_halt[256], exp_busy[256], exp_regs[256];
  int wv[17];
  int m_regs = 0;

  typedef struct {
    int start; int req; int wf; int r1; int alu; int busy; int halted; int pc;
  } vec_t;
  vec_t tbl[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // Program memory: serves mem[addr] after the queued number of stall cycles.
  task automatic respond();
    if (InstrReq) begin
      if (!fetching) begin
        fetching = 1'b1;
        cur_wait = 0;
        if (wait_q.size() > 0) cur_wait = wait_q.pop_front();
      end
      if (cur_wait > 0) begin
        InstrValid = 1'b0;
        InstrData  = 16'($urandom);
        cur_wait--;
      end else begin
        InstrValid = 1'b1;
        InstrData  = mem[InstrAddr];
        fetching   = 1'b0;
      end
    end else begin
      InstrValid = 1'($urandom_range(0, 1));
      InstrData  = 16'($urandom);
      fetching   = 1'b0;
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    cyc++;
    respond();
  endtask

  function automatic logic [31:0] all_outs();
    return {InstrReq, InstrAddr, R1, R2, R3, ALU_Op, WriteFlag, Busy, Halted, PC};
  endfunction

  task automatic do_reset();
    Reset = 1'b1;
    Start = 1'b0;
    next_cycle();
    next_cycle();
    Reset = 1'b0;
    wait_q.delete();
    fetching = 1'b0;
    cur_wait = 0;
  endtask

  // Instruction-level model: each instruction spends (1+w) fetch cycles then
  // decode/execute/writeback; rel cycle 0 is the Start cycle.
  function automatic int build_model(input int L);
    int t = 1, pc = 0, hf = -1, k = 0, w, op, val, alu;
    logic [15:0] ins;
    for (int c = 0; c < 256; c++) begin
      exp_wf[c] = 0; exp_req[c] = 0; exp_pc[c] = 0;
      exp_halt[c] = 0; exp_busy[c] = 0; exp_regs[c] = m_regs;
    end
    while (hf < 0 && k <= L) begin
      w   = wv[k];
      ins = mem[pc];
      op  = int'(ins[15:12]);
      for (int c = t; c <= t + w; c++) exp_req[c] = 1;
      for (int c = t; c <= t + w + 3; c++) begin exp_pc[c] = pc; exp_busy[c] = 1; end
      if (op == 15) begin
        hf = t + w + 2;
        for (int c = hf; c < 256; c++) begin exp_busy[c] = 0; exp_halt[c] = 1; exp_pc[c] = pc; end
      end else begin
        alu = (op >= 1 && op <= 6) ? op : 0;
        val = ((int'(ins[11:9]) * 8 + int'(ins[8:6])) * 8 + int'(ins[5:3])) * 8 + alu;
        for (int c = t + w + 2; c < 256; c++) exp_regs[c] = val;
        m_regs = val;
        if (alu != 0) exp_wf[t + w + 3] = 1;
        pc = (pc + 1) % 256;
        t  = t + w + 4;
        k++;
      end
    end
    if (hf < 0) hf = 200;
    return hf;
  endfunction

  initial begin
    int wf_seen, prev, hf, L;
    bit wrapped, done;

    tbl = '{
      '{1, 0, 0, 0, 0, 0, 0, 0},
      '{0, 1, 0, 0, 0, 1, 0, 0},
      '{0, 0, 0, 0, 0, 1, 0, 0},
      '{0, 0, 0, 1, 1, 1, 0, 0},
      '{0, 0, 1, 1, 1, 1, 0, 0},
      '{0, 1, 0, 1, 1, 1, 0, 1},
      '{0, 0, 0, 1, 1, 1, 0, 1},
      '{0, 0, 0, 4, 2, 1, 0, 1},
      '{0, 0, 1, 4, 2, 1, 0, 1},
      '{0, 1, 0, 4, 2, 1, 0, 2},
      '{0, 0, 0, 4, 2, 1, 0, 2},
      '{0, 0, 0, 4, 2, 0, 1, 2},
      '{0, 0, 0, 4, 2, 0, 1, 2}
    };
    for (int a = 0; a < 256; a++) mem[a] = '0;

    // Reset values held in IDLE.
    do_reset();
    for (int c = 0; c <= 10; c++) begin
      chk("reset_outs", all_outs(), 0);
      if (c < 10) next_cycle();
    end

    // Zero-wait program, cycle table (row 0 is the Start cycle).
    mem[0] = 16'h1298; mem[1] = 16'h2850; mem[2] = 16'hF000;
    for (int i = 0; i < 13; i++) begin
      next_cycle();
      Start = (tbl[i].start != 0);
      chk("tbl_req",    InstrReq,  tbl[i].req);
      chk("tbl_wf",     WriteFlag, tbl[i].wf);
      chk("tbl_r1",     R1,        tbl[i].r1);
      chk("tbl_alu",    ALU_Op,    tbl[i].alu);
      chk("tbl_busy",   Busy,      tbl[i].busy);
      chk("tbl_halted", Halted,    tbl[i].halted);
      chk("tbl_pc",     PC,        tbl[i].pc);
    end
    Start = 1'b0;

    // First fetch stalled 3 cycles: request held 4 cycles, write shifts to 8.
    mem[0] = 16'h1298; mem[1] = 16'hF000;
    wait_q.push_back(3);
    for (int c = 1; c <= 12; c++) begin
      next_cycle();
      Start = (c == 1);
      if (c >= 2 && c <= 5) begin
        chk("stall_req", InstrReq, 1);
        chk("stall_addr", InstrAddr, 0);
      end
      if (c == 6) chk("stall_req_drop", InstrReq, 0);
      chk("stall_wf", WriteFlag, c == 8);
    end

    // NOP and undefined opcode never write.
    mem[0] = 16'h0000; mem[1] = 16'h9FFF; mem[2] = 16'hF000;
    wf_seen = 0;
    for (int c = 1; c <= 16; c++) begin
      next_cycle();
      Start = (c == 1);
      if (WriteFlag) wf_seen++;
      if (c == 8) begin
        chk("undef_alu", ALU_Op, 0);
        chk("undef_r1", R1, 7);
      end
    end
    chk("nop_no_write", wf_seen, 0);
    chk("nop_halted", Halted, 1);
    chk("nop_pc", PC, 2);

    // PC wrap: HALT at address 3 appears only once address 255 was fetched.
    for (int a = 0; a < 256; a++) mem[a] = '0;
    wrapped = 1'b0; done = 1'b0; prev = 0;
    for (int n = 0; n < 1200 && !done; n++) begin
      next_cycle();
      Start = (n == 0);
      if (InstrReq && InstrAddr == 8'd255) mem[3] = 16'hF000;
      if (n >= 2 && int'(PC) != prev) begin
        chk("wrap_pc_step", PC, (prev + 1) % 256);
        if (prev == 255) wrapped = 1'b1;
      end
      if (n >= 1) prev = int'(PC);
      if (n > 0 && Halted) done = 1'b1;
    end
    chk("wrap_reached_halt", done, 1);
    chk("wrap_seen", wrapped, 1);
    chk("wrap_halt_pc", PC, 3);

    // Reset during the WRITEBACK of the second ADD.
    mem[0] = 16'h1298; mem[1] = 16'h2850; mem[2] = 16'hF000;
    for (int c = 1; c <= 9; c++) begin
      next_cycle();
      Start = (c == 1);
    end
    chk("mid_pre_wf", WriteFlag, 1);
    Reset = 1'b1;
    #1;
    chk("mid_reset_wf", WriteFlag, 0);
    next_cycle();
    Reset = 1'b0;
    chk("mid_reset_outs", all_outs(), 0);
    Start = 1'b1;
    next_cycle();
    Start = 1'b0;
    chk("mid_refetch_req", InstrReq, 1);
    chk("mid_refetch_addr", InstrAddr, 0);

    // Random programs with random stalls and spurious Start while busy.
    do_reset();
    m_regs = 0;
    for (int p = 0; p < 6; p++) begin
      L = int'($urandom_range(3, 16));
      for (int a = 0; a < L; a++) mem[a] = {4'($urandom_range(0, 14)), 12'($urandom)};
      mem[L] = {4'hF, 12'($urandom)};
      for (int k = 0; k <= L; k++) begin
        wv[k] = int'($urandom_range(0, 3));
        wait_q.push_back(wv[k]);
      end
      hf = build_model(L);
      for (int c = 0; c <= hf + 2; c++) begin
        next_cycle();
        if (c == 0) Start = 1'b1;
        else if (c < hf) Start = ($urandom_range(0, 3) == 0);
        else Start = 1'b0;
        if (c >= 1) begin
          chk("rnd_wf",     WriteFlag, exp_wf[c]);
          chk("rnd_req",    InstrReq,  exp_req[c]);
          chk("rnd_pc",     PC,        exp_pc[c]);
          chk("rnd_halted", Halted,    exp_halt[c]);
          chk("rnd_busy",   Busy,      exp_busy[c]);
          chk("rnd_regs",   {20'd0, R1, R2, R3, ALU_Op}, exp_regs[c]);
          if (InstrReq) chk("rnd_addr", InstrAddr, exp_pc[c]);
        end
      end
      wait_q.delete();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Multi-cycle control stage that sits directly upstream of the register file and ALU. It fetches 16-bit instructions from program memory over a request/valid handshake and decodes them. It drives the register pointers R1/R2/R3 and the ALU operation select. It pulses WriteFlag for exactly one cycle per register-writing instruction, so the register file captures ALU_Result.

## Interface

**Parameters**
- PC_W, 8, program counter / instruction address width
- DATA_W, 13, datapath width (informational; must match register file and ALU)

**Ports**
- clk  input  1  rising-edge clock
- Reset  input  1  reset, synchronous, active-high
- Start  input  1  begin execution at address 0; honoured only in IDLE or HALTED
- InstrReq  output  1  fetch request to program memory
- InstrAddr  output  PC_W  fetch address (equals PC)
- InstrData  input  16  instruction word, sampled when InstrReq && InstrValid
- InstrValid  input  1  memory response strobe
- R1  output  3  destination register pointer
- R2  output  3  source A register pointer
- R3  output  3  source B register pointer
- ALU_Op  output  3  ALU operation select
- WriteFlag  output  1  register-file write enable, one-cycle pulse
- Busy  output  1  high in FETCH, DECODE, EXECUTE, WRITEBACK
- Halted  output  1  high in HALTED
- PC  output  PC_W  current program counter

## Operation

**Instruction word**
- Opcode is [15:12].
- R1 is [11:9], R2 is [8:6], R3 is [5:3].
- Bits [2:0] are ignored.

**Opcodes and ALU_Op**
- 0 NOP: ALU_Op 0, no write.
- 1 ADD: ALU_Op 1.
- 2 SUB: ALU_Op 2.
- 3 AND: ALU_Op 3.
- 4 OR: ALU_Op 4.
- 5 XOR: ALU_Op 5.
- 6 PASS (R1 ← R2): ALU_Op 6.
- 15 HALT.
- All other opcodes (7–14) execute as NOP.
- Opcodes 1–6 write the register file.

**State machine: IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, HALTED**
- IDLE: Start=1 → PC←0, go to FETCH.
- FETCH: InstrReq=1, InstrAddr=PC. When InstrValid=1, latch InstrData into the instruction register and go to DECODE. Otherwise stay in FETCH, with InstrReq and InstrAddr held.
- DECODE: register R1/R2/R3 and ALU_Op from the instruction register.
  - HALT → go to HALTED.
  - Otherwise → go to EXECUTE.
- EXECUTE: outputs held for one cycle while the ALU settles. Go to WRITEBACK.
- WRITEBACK: WriteFlag=1 if the opcode writes. R1/R2/R3/ALU_Op are unchanged. PC←PC+1 (mod 2^PC_W). Go to FETCH.
- HALTED: PC is frozen at the HALT instruction's address. Start=1 → PC←0, go to FETCH. Otherwise stay.

**Output rules**
- R1/R2/R3/ALU_Op are registered. They change only on entry to EXECUTE (the DECODE→EXECUTE edge). They hold their value until the next instruction's decode.
- InstrReq is asserted only in FETCH.
- WriteFlag is asserted only in WRITEBACK.
- PC wraps from 2^PC_W−1 to 0 with no flag.

**Reset**
- Reset is synchronous and overrides all other inputs on any cycle, including mid-fetch.
- After Reset: state=IDLE, PC=0, instruction register=0, R1=R2=R3=0, ALU_Op=0, WriteFlag=0, InstrReq=0, InstrAddr=0, Busy=0, Halted=0.
- A WriteFlag pulse pending in the Reset cycle is suppressed.

## Timing

**Per-instruction latency**
- Instruction cycles = 4 + w, where w is the number of FETCH cycles with InstrValid=0.
- FETCH (≥1), DECODE (1), EXECUTE (1), WRITEBACK (1).

**Zero-wait throughput**
- One instruction per 4 cycles.
- WriteFlag pulses are 4 cycles apart.

**Start and memory**
- Start→first InstrReq: 1 cycle (Start sampled in IDLE; FETCH in the next cycle).
- InstrValid outside FETCH is ignored.
- Start while Busy is ignored.
- Start and Reset in the same cycle: Reset wins.

**HALT**
- HALT: DECODE→HALTED takes 1 cycle.
- No WriteFlag for HALT.
- Halted rises the cycle after DECODE.

## Test plan

- **Reset values:** Reset for 2 cycles, then release with Start=0. All outputs must be 0 and the state must remain IDLE for 10 cycles.
- **Zero-wait program:** memory with InstrValid always 1. Program: ADD R1=1,R2=2,R3=3 (0x1298); SUB R1=4,R2=1,R3=2 (0x2850); HALT (0xF000).
  - WriteFlag must pulse in cycles 5 and 9 after Start, with R1=1 then R1=4 during the pulse.
  - Halted=1 with PC=2 from cycle 12.
- **Fetch stall:** InstrValid delayed 3 cycles for the first fetch. InstrReq and InstrAddr=0 must be held for 4 cycles. The first WriteFlag must shift by exactly 3 cycles.
- **NOP/undefined:** program 0x0000, 0x9FFF, HALT. There must be no WriteFlag at all. PC must reach 2 and Halted=1.
- **PC wrap:** memory filled with NOP, with HALT only at address 3. Force execution past 255 (PC_W=8).
  - PC must go 255→0 and continue.
  - HALTED must be entered at address 3 after wrap.
- **Reset mid-operation:** assert Reset in a WRITEBACK cycle of an ADD.
  - WriteFlag=0 in that cycle.
  - The next cycle shows IDLE with all outputs 0.
  - A subsequent Start refetches from address 0.
